ndp_job_scheduler: RTL

- Shares one NDP_core among NUM_REQ requesters, for example several host DMA queues.
- Accepts per-requester job descriptors (length, ReLU flag) and grants jobs round-robin.
- Per job: holds the core's config stable, releases the core from reset, steers the winner's input stream in, and tags the 64-bit result stream with the requester ID.
- After the core's done pulse, returns the core to reset so it cannot self-restart between jobs.

---
 rtl/ndp_sched_pkg.sv | 28 ++
 rtl/ndp_job_scheduler_if.sv | 57 +++++
 rtl/ndp_rr_arbiter.sv | 31 +++
 rtl/ndp_job_scheduler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ndp_sched_pkg.sv
// Shared types, widths and the round-robin search helper for the NDP job scheduler.
package ndp_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_LAUNCH  = 3'd2,
        S_RUN     = 3'd3,
        S_RECOVER = 3'd4
    } sched_state_t;

    localparam int CORE_OUT_W = 64;
    localparam int CORE_IN_W  = 1088;

    // Returns {found, index}. Bits at or above NUM_REQ must be zero, so searching
    // the full 16-entry ring gives the same order as wrapping at NUM_REQ.
    function automatic logic [4:0] rr_next(input logic [15:0] valid, input logic [3:0] ptr);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!res[4] && valid[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

endpackage

// File: rtl/ndp_job_scheduler_if.sv
// Requester, core and result-stream signal bundle for ndp_job_scheduler.
interface ndp_job_scheduler_if
    import ndp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int IN_W    = CORE_IN_W
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*32-1:0]   req_length;
    logic [NUM_REQ-1:0]      req_relu;
    logic [NUM_REQ-1:0]      job_done;
    logic [NUM_REQ-1:0]      job_err;
    logic                    busy;
    logic [ID_W-1:0]         cur_id;
    logic [NUM_REQ*IN_W-1:0] s_axis_tdata;
    logic [NUM_REQ-1:0]      s_axis_tvalid;
    logic [NUM_REQ-1:0]      s_axis_tready;
    logic                    core_aresetn;
    logic                    core_is_relu;
    logic [31:0]             core_length;
    logic [IN_W-1:0]         core_s_tdata;
    logic                    core_s_tvalid;
    logic                    core_s_tready;
    logic                    core_done;
    logic [CORE_OUT_W-1:0]   core_m_tdata;
    logic                    core_m_tvalid;
    logic                    core_m_tlast;
    logic                    core_m_tready;
    logic [CORE_OUT_W-1:0]   m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic [ID_W-1:0]         m_axis_tdest;
    logic                    m_axis_tready;

    // Environment side: requesters, the NDP core and the result sink.
    modport master (
        output req_valid, req_length, req_relu, s_axis_tdata, s_axis_tvalid,
               core_s_tready, core_done, core_m_tdata, core_m_tvalid, core_m_tlast,
               m_axis_tready,
        input  req_ready, job_done, job_err, busy, cur_id, s_axis_tready,
               core_aresetn, core_is_relu, core_length, core_s_tdata, core_s_tvalid,
               core_m_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_length, req_relu, s_axis_tdata, s_axis_tvalid,
               core_s_tready, core_done, core_m_tdata, core_m_tvalid, core_m_tlast,
               m_axis_tready,
        output req_ready, job_done, job_err, busy, cur_id, s_axis_tready,
               core_aresetn, core_is_relu, core_length, core_s_tdata, core_s_tvalid,
               core_m_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );

endinterface

// File: rtl/ndp_rr_arbiter.sv
// Combinational round-robin picker; the pointer moves past the winner on advance.
module ndp_rr_arbiter
    import ndp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    input  logic [ID_W-1:0]    adv_id,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_vld
);
    logic [ID_W-1:0] rr_ptr;
    logic [4:0]      pick;

    assign pick      = rr_next(16'(valid), 4'(rr_ptr));
    assign grant_vld = pick[4];
    assign grant_id  = ID_W'(pick[3:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (adv_id == ID_W'(NUM_REQ - 1)) ? '0 : adv_id + 1'b1;
        end
    end

endmodule

// File: rtl/ndp_job_scheduler.sv
// Round-robin sharing of one NDP core among NUM_REQ requesters with per-job core reset.
// Optional watchdog: define NDP_SCHED_TIMEOUT_EN to abort jobs after TIMEOUT_CYCLES in RUN.
module ndp_job_scheduler
    import ndp_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int IN_W           = CORE_IN_W,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input logic                clk,
    input logic                reset,
    ndp_job_scheduler_if.slave bus
);
    localparam logic [2:0] IDLE    = S_IDLE;
    localparam logic [2:0] GRANT   = S_GRANT;
    localparam logic [2:0] LAUNCH  = S_LAUNCH;
    localparam logic [2:0] RUN     = S_RUN;
    localparam logic [2:0] RECOVER = S_RECOVER;

    logic [2:0]         state;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    pick_id;
    logic               pick_vld;
    logic [NUM_REQ-1:0] id_oh;
    logic [31:0]        sel_len;
    logic               sel_relu;
    logic [31:0]        rcnt;
    logic               aresetn_r;
    logic               relu_r;
    logic [31:0]        len_r;
    logic [NUM_REQ-1:0] done_r;
    logic [NUM_REQ-1:0] err_r;
    logic               run;

    assign id_oh    = NUM_REQ'(1) << cur_id;
    assign sel_len  = bus.req_length[32*cur_id +: 32];
    assign sel_relu = bus.req_relu[cur_id];
    assign run      = (state == RUN);

    ndp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (bus.req_valid),
        .advance   (state == GRANT),
        .adv_id    (cur_id),
        .grant_id  (pick_id),
        .grant_vld (pick_vld)
    );

`ifdef NDP_SCHED_TIMEOUT_EN
    logic [31:0] to_cnt;

    always_ff @(posedge clk) begin
        if (state == LAUNCH) to_cnt <= '0;
        else if (run)        to_cnt <= to_cnt + 32'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_id    <= '0;
            aresetn_r <= 1'b0;
            relu_r    <= 1'b0;
            len_r     <= '0;
            done_r    <= '0;
            err_r     <= '0;
            rcnt      <= '0;
        end else begin
            done_r <= '0;
            err_r  <= '0;
            case (state)
                IDLE: begin
                    aresetn_r <= 1'b0;
                    if (pick_vld) begin
                        cur_id <= pick_id;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    len_r  <= sel_len;
                    relu_r <= sel_relu;
                    // A zero-length job would never see core_done, so reject it here.
                    if (sel_len == 32'd0) begin
                        err_r <= id_oh;
                        state <= IDLE;
                    end else begin
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    aresetn_r <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (bus.core_done) begin
                        done_r    <= id_oh;
                        aresetn_r <= 1'b0;
                        rcnt      <= 32'(RST_CYCLES - 1);
                        state     <= RECOVER;
                    end
`ifdef NDP_SCHED_TIMEOUT_EN
                    else if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        err_r     <= id_oh;
                        aresetn_r <= 1'b0;
                        rcnt      <= 32'(RST_CYCLES - 1);
                        state     <= RECOVER;
                    end
`endif
                end
                RECOVER: begin
                    if (rcnt == 32'd0) state <= IDLE;
                    else               rcnt  <= rcnt - 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stream steering is purely combinational and only open while RUN.
    assign bus.req_ready     = (state == GRANT) ? id_oh : '0;
    assign bus.s_axis_tready = (run && bus.core_s_tready) ? id_oh : '0;
    assign bus.core_s_tvalid = run && bus.s_axis_tvalid[cur_id];
    assign bus.core_s_tdata  = run ? bus.s_axis_tdata[IN_W*cur_id +: IN_W] : '0;
    assign bus.m_axis_tdata  = bus.core_m_tdata;
    assign bus.m_axis_tvalid = run && bus.core_m_tvalid;
    assign bus.m_axis_tlast  = run && bus.core_m_tlast;
    assign bus.m_axis_tdest  = cur_id;
    assign bus.core_m_tready = run && bus.m_axis_tready;

    assign bus.busy         = (state != IDLE);
    assign bus.cur_id       = cur_id;
    assign bus.core_aresetn = aresetn_r;
    assign bus.core_is_relu = relu_r;
    assign bus.core_length  = len_r;
    assign bus.job_done     = done_r;
    assign bus.job_err      = err_r;

endmodule
